// File: rtl/mme_accum_drain.sv
// Accumulator drain: snapshots the PE array accumulators into a shadow
// buffer, clears the array, then streams the results out row-major.
module mme_accum_drain #(
    parameter int unsigned DW     = 32,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned AW     = 2 * DW + 1,
    parameter bit          SAT_EN = 1'b1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start_i,
    input  logic [ROWS*COLS*AW-1:0]                 accum_i,
    output logic                                    clr_o,
    output logic                                    busy_o,
    output logic                                    out_valid_o,
    input  logic                                    out_ready_i,
    output logic [DW-1:0]                           out_data_o,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row_o,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] out_col_o,
    output logic                                    out_last_o,
    output logic                                    out_sat_o,
    output logic                                    done_o,
    output logic                                    overrun_o
);

    localparam int unsigned N  = ROWS * COLS;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic          clr_q, clr_d;
    logic          done_q, done_d;
    logic          ovr_q, ovr_d;
    logic          cap;
    logic [AW-1:0] buf_q [N];

    logic          drain;
    logic          last;
    logic [AW-1:0] v;
    logic [AW-DW:0] hi;
    logic          ovf;

    assign drain = (state_q == DRAIN);
    assign last  = (idx_q == IW'(N - 1));

    // Control state, beat index and one-cycle pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            clr_q   <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            row_q   <= row_d;
            col_q   <= col_d;
            clr_q   <= clr_d;
            done_q  <= done_d;
            ovr_q   <= ovr_d;
        end
    end

    // Next-state: capture in IDLE, advance on each accepted beat in DRAIN
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        row_d   = row_q;
        col_d   = col_q;
        clr_d   = 1'b0;
        done_d  = 1'b0;
        ovr_d   = ovr_q;
        cap     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = DRAIN;
                    idx_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                    clr_d   = 1'b1;
                    cap     = 1'b1;
                end
            end
            DRAIN: begin
                if (start_i) begin
                    ovr_d = 1'b1;
                end
                if (out_ready_i) begin
                    if (last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        row_d   = '0;
                        col_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (col_q == CW'(COLS - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Shadow buffer: loaded only at capture, isolated from accum_i afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= '0;
            end
        end else if (cap) begin
            for (int i = 0; i < N; i++) begin
                buf_q[i] <= accum_i[i*AW +: AW];
            end
        end
    end

    // Result formatting: value fits in DW iff the bits above DW-2 are all sign
    always_comb begin
        v           = buf_q[idx_q];
        hi          = v[AW-1:DW-1];
        ovf         = SAT_EN && !((&hi) || !(|hi));
        out_valid_o = 1'b0;
        out_data_o  = '0;
        out_row_o   = '0;
        out_col_o   = '0;
        out_last_o  = 1'b0;
        out_sat_o   = 1'b0;
        if (drain) begin
            out_valid_o = 1'b1;
            out_row_o   = row_q;
            out_col_o   = col_q;
            out_last_o  = last;
            out_sat_o   = ovf;
            if (ovf) begin
                out_data_o = v[AW-1] ? {1'b1, {(DW-1){1'b0}}}
                                     : {1'b0, {(DW-1){1'b1}}};
            end else begin
                out_data_o = v[DW-1:0];
            end
        end
    end

    assign clr_o     = clr_q;
    assign busy_o    = drain;
    assign done_o    = done_q;
    assign overrun_o = ovr_q;

endmodule

// File: doc/mme_accum_drain.md
Name: mme_accum_drain

Overview:
Reader side of the systolic PE array's accumulator outputs. On a start pulse, captures all ROWS*COLS accumulators into a shadow buffer and pulses a clear back to the array, so the next tile can begin computing. Then streams the captured results out row-major over a valid/ready interface, one element per handshake. Each result is saturated or truncated to DW bits for writeback to memory.

Parameters:
DW, 32, PE operand width; output element width
ROWS, 4, PE array rows
COLS, 4, PE array columns
AW, 2*DW+1, accumulator width per PE (fixed by PE accum_o width)
SAT_EN, 1, 1 = signed saturate AW->DW; 0 = keep low DW bits (wrap)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
start_i  input  1  one-cycle pulse: array results valid, begin drain
accum_i  input  ROWS*COLS*AW  flattened accumulators; element (r,c) at [(r*COLS+c)*AW +: AW], signed
clr_o  output  1  one-cycle clear pulse to PE array clr_i
busy_o  output  1  1 from capture until last beat accepted
out_valid_o  output  1  output element valid
out_ready_i  input  1  downstream ready
out_data_o  output  DW  signed result element
out_row_o  output  clog2(ROWS) (min 1)  row index of current element
out_col_o  output  clog2(COLS) (min 1)  column index of current element
out_last_o  output  1  current element is (ROWS-1,COLS-1)
out_sat_o  output  1  current element was clipped (always 0 when SAT_EN=0)
done_o  output  1  one-cycle pulse after last beat accepted
overrun_o  output  1  sticky: start_i seen while busy

Behaviour:
- Reset (async, rst=1): FSM=IDLE, idx=0, shadow buffer cleared to 0; clr_o, busy_o, out_valid_o, out_last_o, out_sat_o, done_o, overrun_o, out_data_o, out_row_o, out_col_o all 0. Reset mid-drain abandons the transfer without producing done_o.
- FSM states: IDLE, DRAIN.
- IDLE: on start_i=1 at a clock edge, latch all accum_i into the shadow buffer, set idx=0, go to DRAIN. In the following cycle, clr_o=1 for exactly one cycle and busy_o=1.
- DRAIN: out_valid_o=1 starting the cycle after capture (one-cycle latency start->valid). Outputs are driven combinationally from buffer[idx]. out_row_o = idx / COLS, out_col_o = idx % COLS, out_last_o = (idx == ROWS*COLS-1).
- Handshake: a beat transfers when out_valid_o & out_ready_i at a clock edge, then idx increments. out_data_o, the index outputs and out_sat_o stay stable while valid=1 and ready=0. Valid never drops before the beat transfers.
- Last beat accepted: next cycle has FSM=IDLE, out_valid_o=0, busy_o=0, done_o=1 for one cycle. A start_i in that same done cycle is accepted normally.
- Back-to-back: full throughput of 1 element/cycle with ready held high. Total drain takes ROWS*COLS cycles after valid rises.
- start_i while busy (DRAIN): ignored, no recapture and no clr_o; overrun_o set to 1 and held until rst.
- start_i on the same edge as the final handshake: FSM is still DRAIN at that edge, so it is treated as an overrun.
- Arithmetic, SAT_EN=1: if v > 2^(DW-1)-1, output 2^(DW-1)-1 with sat=1. If v < -2^(DW-1), output -2^(DW-1) with sat=1. Otherwise output v[DW-1:0] with sat=0.
- Arithmetic, SAT_EN=0: output v[DW-1:0], sat=0.
- The shadow buffer is isolated from accum_i after capture, so array activity after clr_o does not affect drained data.

Test Plan:
- ROWS=COLS=2, DW=8, accum = {(0,0)=5, (0,1)=-3, (1,0)=100, (1,1)=-128}, start pulse, ready=1 -> clr_o one cycle after start; 4 beats 5, -3, 100, -128 with (row,col) = (0,0),(0,1),(1,0),(1,1); last only on beat 4; done_o the cycle after beat 4; sat=0 throughout.
- Saturation, DW=8, SAT_EN=1, accum (0,0)=300, (0,1)=-200 -> out 127 sat=1, then -128 sat=1. Same inputs with SAT_EN=0 -> 44 and 56, sat=0.
- Backpressure: ready toggles 1,0,0,1,0,1,1 -> data and index stay stable while stalled; exactly 4 beats in order; no duplicates or drops.
- Capture isolation: accum_i changed to all 0x7 the cycle after start -> drained values equal the pre-change capture.
- start_i pulsed during beat 2 -> no second clr_o, drain unaffected, overrun_o=1 and still 1 after done_o; cleared only by rst.
- rst asserted asynchronously mid-drain (between clock edges) -> all outputs 0 immediately; no done_o; a fresh start_i after release drains correctly from idx 0.
